line_pp_ctrl: RTL and testbench

Write/read sequencer for the two-RAM ping-pong line buffer (`data_save`). It turns the incoming active-pixel qualifier into the buffer's write controls: `effect_reigon`, `wr_addr1`, `wr_addr2` and `pp_flagw`. It tracks which RAM holds a complete line, drives `pp_flagr` and a line-ready handshake to the send side, and flags overflow and over-length lines.

---
 rtl/line_buf_pkg.sv | 22 ++
 rtl/line_pp_ctrl.sv | 154 +++++++++++++++
 tb/tb_line_pp_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_buf_pkg.sv
// Shared definitions for the ping-pong line buffer (data_save and line_pp_ctrl).
package line_buf_pkg;

  typedef logic buf_idx_t;

  localparam logic PP_FLAGW_RST = 1'b1;
  localparam logic PP_FLAGR_RST = 1'b0;

  // Number of bits needed to represent value (0 for value == 0).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/line_pp_ctrl.sv
// Write/read sequencer for the two-RAM ping-pong line buffer: write strobes and
// pointers, per-buffer full/length tracking, line-ready handshake and error flags.
module line_pp_ctrl
  import line_buf_pkg::*;
#(
  parameter  int unsigned RAM_DEPTH  = 100,
  localparam int unsigned ADDR_WIDTH = clogb2(RAM_DEPTH - 1)
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic                  ce,
  input  logic                  de,
  input  logic                  rd_done,
  input  logic                  err_clr,
  output logic                  effect_reigon,
  output logic [ADDR_WIDTH-1:0] wr_addr1,
  output logic [ADDR_WIDTH-1:0] wr_addr2,
  output logic                  pp_flagw,
  output logic                  pp_flagr,
  output logic                  line_rdy,
  output logic [ADDR_WIDTH:0]   line_len,
  output logic                  ovf,
  output logic                  len_err
);

  localparam int unsigned        CNT_W   = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(RAM_DEPTH);

  logic                  r_pp_flagw;
  buf_idx_t              r_rb;
  logic [1:0]            r_full;
  logic [CNT_W-1:0]      r_len0;
  logic [CNT_W-1:0]      r_len1;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_de_d1;
  logic                  r_effect;
  logic [ADDR_WIDTH-1:0] r_wr_addr1;
  logic [ADDR_WIDTH-1:0] r_wr_addr2;
  logic                  r_ovf;
  logic                  r_len_err;

  buf_idx_t              w_wb;
  buf_idx_t              w_wb_nxt;
  logic                  w_wr_cyc;
  logic                  w_line_end;
  logic                  w_over;
  logic                  w_release;
  logic                  w_commit;
  logic                  w_drop;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [1:0]            w_full_nxt;

  // Event decode; the release is applied before the commit decision so a
  // same-cycle rd_done can free the buffer the finished line lives in.
  always_comb begin
    w_wb       = buf_idx_t'(~r_pp_flagw);
    w_wr_cyc   = ce & r_effect;
    w_line_end = ce & r_de_d1 & ~de;
    w_over     = ce & r_de_d1 & (r_cnt == DEPTH_C);
    w_release  = rd_done & r_full[r_rb];
    w_cnt_inc  = r_cnt + CNT_W'(w_wr_cyc);
    w_commit   = w_line_end & (~r_full[w_wb] | (w_release & (r_rb == w_wb)));
    w_drop     = w_line_end & ~w_commit;
    w_wb_nxt   = w_wb ^ w_commit;

    w_cnt_nxt = r_cnt;
    if (ce) begin
      w_cnt_nxt = w_line_end ? '0 : w_cnt_inc;
    end

    w_full_nxt = r_full;
    if (w_release) begin
      w_full_nxt[r_rb] = 1'b0;
    end
    if (w_commit) begin
      w_full_nxt[w_wb] = 1'b1;
    end
  end

  // Buffer ownership and write pointers; the idle buffer's pointer is held at 0.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_pp_flagw <= PP_FLAGW_RST;
      r_rb       <= buf_idx_t'(PP_FLAGR_RST);
      r_full     <= '0;
      r_cnt      <= '0;
      r_wr_addr1 <= '0;
      r_wr_addr2 <= '0;
    end else begin
      r_pp_flagw <= ~w_wb_nxt;
      r_rb       <= r_rb ^ w_release;
      r_full     <= w_full_nxt;
      r_cnt      <= w_cnt_nxt;
      r_wr_addr1 <= (w_wb_nxt == 1'b0) ? w_cnt_nxt[ADDR_WIDTH-1:0] : '0;
      r_wr_addr2 <= (w_wb_nxt == 1'b1) ? w_cnt_nxt[ADDR_WIDTH-1:0] : '0;
    end
  end

  // Write strobe: one cycle behind de to line up with the data register.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_de_d1  <= 1'b0;
      r_effect <= 1'b0;
    end else if (ce) begin
      r_de_d1  <= de;
      r_effect <= de & (w_cnt_inc < DEPTH_C);
    end
  end

  // Stored line lengths include the final write committing at the line-end edge.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_len0 <= '0;
      r_len1 <= '0;
    end else if (w_commit) begin
      if (w_wb == 1'b1) begin
        r_len1 <= w_cnt_inc;
      end else begin
        r_len0 <= w_cnt_inc;
      end
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      r_ovf     <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (err_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_over) begin
        r_len_err <= 1'b1;
      end else if (err_clr) begin
        r_len_err <= 1'b0;
      end
    end
  end

  assign effect_reigon = r_effect;
  assign wr_addr1      = r_wr_addr1;
  assign wr_addr2      = r_wr_addr2;
  assign pp_flagw      = r_pp_flagw;
  assign pp_flagr      = r_rb;
  assign line_rdy      = r_full[r_rb];
  assign line_len      = (r_rb == 1'b1) ? r_len1 : r_len0;
  assign ovf           = r_ovf;
  assign len_err       = r_len_err;

endmodule

// File: tb/tb_line_pp_ctrl.sv
// Self-checking bench for line_pp_ctrl: directed scenarios plus randomized lines,
// compared against a line-level model (queue of stored line lengths).
module tb_line_pp_ctrl;

  localparam int unsigned D  = 100;
  localparam int unsigned AW = 7;

  logic          clk;
  logic          sclr;
  logic          ce;
  logic          de;
  logic          rd_done;
  logic          err_clr;
  logic          effect_reigon;
  logic [AW-1:0] wr_addr1;
  logic [AW-1:0] wr_addr2;
  logic          pp_flagw;
  logic          pp_flagr;
  logic          line_rdy;
  logic [AW:0]   line_len;
  logic          ovf;
  logic          len_err;

  int checks = 0;
  int errors = 0;

  // Model: lines waiting to be read (oldest first), commit/release counts.
  int          q[$];
  int unsigned com;
  int unsigned rel;
  int unsigned pix;
  bit          in_line;
  bit          m_eff;
  int unsigned m_addr;
  bit          m_ovf;
  bit          m_len_err;
  int          wr_seen;

  line_pp_ctrl #(.RAM_DEPTH(D)) dut (
    .clk          (clk),
    .sclr         (sclr),
    .ce           (ce),
    .de           (de),
    .rd_done      (rd_done),
    .err_clr      (err_clr),
    .effect_reigon(effect_reigon),
    .wr_addr1     (wr_addr1),
    .wr_addr2     (wr_addr2),
    .pp_flagw     (pp_flagw),
    .pp_flagr     (pp_flagr),
    .line_rdy     (line_rdy),
    .line_len     (line_len),
    .ovf          (ovf),
    .len_err      (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rnd(input int unsigned pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  function automatic void model_reset();
    q.delete();
    com       = 0;
    rel       = 0;
    pix       = 0;
    in_line   = 0;
    m_eff     = 0;
    m_addr    = 0;
    m_ovf     = 0;
    m_len_err = 0;
  endfunction

  task automatic check_all();
    int unsigned wbuf;
    wbuf = com % 2;
    chk("effect_reigon", 32'(effect_reigon), 32'(m_eff));
    chk("wr_addr1", 32'(wr_addr1), (wbuf == 0) ? m_addr : 32'd0);
    chk("wr_addr2", 32'(wr_addr2), (wbuf == 1) ? m_addr : 32'd0);
    chk("pp_flagw", 32'(pp_flagw), (wbuf == 0) ? 32'd1 : 32'd0);
    chk("pp_flagr", 32'(pp_flagr), rel % 2);
    chk("line_rdy", 32'(line_rdy), (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) chk("line_len", 32'(line_len), 32'(q[0]));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("len_err", 32'(len_err), 32'(m_len_err));
  endtask

  // One clock: drive inputs just after a falling edge, check at the next one.
  task automatic step(input logic c, input logic d, input logic r, input logic e);
    bit          set_ovf;
    bit          set_len;
    int unsigned len;
    ce      = c;
    de      = d;
    rd_done = r;
    err_clr = e;
    @(negedge clk);
    set_ovf = 0;
    set_len = 0;
    if (r && q.size() > 0) begin
      q.delete(0);
      rel++;
    end
    if (c) begin
      if (d) begin
        if (pix > D) set_len = 1;
        m_eff   = (pix < D);
        m_addr  = (pix < D) ? pix : D;
        pix++;
        in_line = 1;
      end else if (in_line) begin
        if (pix > D) set_len = 1;
        len = (pix < D) ? pix : D;
        if (q.size() < 2) begin
          q.push_back(int'(len));
          com++;
        end else begin
          set_ovf = 1;
        end
        m_eff   = 0;
        m_addr  = 0;
        pix     = 0;
        in_line = 0;
      end
    end
    m_ovf     = set_ovf | (m_ovf & ~e);
    m_len_err = set_len | (m_len_err & ~e);
    check_all();
  endtask

  task automatic send_line(input int unsigned k, input int unsigned rd_pct,
                           input int unsigned frz_pct, input logic rd_end,
                           input logic clr_end);
    wr_seen = 0;
    for (int i = 0; i < int'(k); i++) begin
      if (rnd(frz_pct)) step(1'b0, rnd(50), rnd(rd_pct), 1'b0);
      step(1'b1, 1'b1, rnd(rd_pct), 1'b0);
      if (effect_reigon === 1'b1) wr_seen++;
    end
    step(1'b1, 1'b0, rd_end, clr_end);
  endtask

  task automatic do_reset();
    sclr    = 1'b1;
    ce      = 1'b0;
    de      = 1'b0;
    rd_done = 1'b0;
    err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    sclr = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single 10-pixel line, reader idle.
    send_line(10, 0, 0, 1'b0, 1'b0);
    chk("t1_writes", 32'(wr_seen), 32'd10);

    // 10/20/30 lines, each released after it lands.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    send_line(20, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    send_line(30, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Three lines with no reader: third overflows.
    do_reset();
    send_line(8, 0, 0, 1'b0, 1'b0);
    send_line(12, 0, 0, 1'b0, 1'b0);
    send_line(15, 0, 0, 1'b0, 1'b0);
    chk("t3_ovf", 32'(ovf), 32'd1);
    chk("t3_len", 32'(line_len), 32'd8);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);

    // Over-length line.
    send_line(120, 0, 0, 1'b0, 1'b0);
    chk("t4_writes", 32'(wr_seen), 32'(D));
    chk("t4_len", 32'(line_len), 32'(D));
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Line end coinciding with release while both buffers are full.
    send_line(5, 0, 0, 1'b0, 1'b0);
    send_line(6, 0, 0, 1'b0, 1'b0);
    send_line(7, 0, 0, 1'b1, 1'b0);
    chk("t5_no_ovf", 32'(ovf), 32'd0);

    // Overflow together with err_clr: the set wins.
    send_line(4, 0, 0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);

    // Randomized lines, reads, gaps and clock-enable stalls.
    for (int n = 0; n < 40; n++) begin
      int unsigned k;
      int unsigned rp;
      k  = ($urandom_range(0, 9) == 0) ? $urandom_range(D + 1, D + 15) : $urandom_range(1, D);
      rp = $urandom_range(0, 8);
      send_line(k, rp, 10, rnd(20), rnd(10));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step(1'b1, 1'b0, rnd(40), rnd(10));
      end
    end

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    sclr = 1'b1;
    de   = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    sclr = 1'b0;
    send_line(12, 0, 0, 1'b0, 1'b0);
    chk("t8_writes", 32'(wr_seen), 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
